// File: rtl/instr_pkg.sv
// Shared definitions for the instruction assembler and the decoder:
// default stream geometry and the assembler state encoding.
package instr_pkg;

  localparam int unsigned INSTR_WORD_W    = 8;
  localparam int unsigned INSTR_MAX_WORDS = 3;
  localparam int unsigned INSTR_LEN_LSB   = 6;
  localparam int unsigned INSTR_LEN_W     = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } instr_state_e;

endpackage

// File: rtl/instr_assembler_if.sv
// Word stream in / assembled instruction out handshake bundle.
// master: fetch stream plus decoder side; slave: the assembler.
interface instr_assembler_if import instr_pkg::*; #(
  parameter int unsigned WORD_W    = INSTR_WORD_W,
  parameter int unsigned MAX_WORDS = INSTR_MAX_WORDS
) ();

  localparam int unsigned LEN_OUT_W = $clog2(MAX_WORDS + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [WORD_W-1:0]             in_word;
  logic                          op_valid;
  logic                          op_ready;
  logic [WORD_W*MAX_WORDS-1:0]   opcode;
  logic [LEN_OUT_W-1:0]          op_len;

  modport master (
    output in_valid, in_word, op_ready,
    input  in_ready, op_valid, opcode, op_len
  );

  modport slave (
    input  in_valid, in_word, op_ready,
    output in_ready, op_valid, opcode, op_len
  );

endinterface

// File: rtl/instr_len_decode.sv
// Length field of word0 -> number of words in the instruction.
// need is one bit wider than the field so that field+1 never wraps.
module instr_len_decode import instr_pkg::*; #(
  parameter int unsigned MAX_WORDS = INSTR_MAX_WORDS,
  parameter int unsigned LEN_W     = INSTR_LEN_W
) (
  input  logic [LEN_W-1:0] len_field_i,
  output logic [LEN_W:0]   need_o,
  output logic             illegal_o
);

  // need = field + 1; anything beyond MAX_WORDS is not representable
  always_comb begin
    need_o    = (LEN_W+1)'(len_field_i) + (LEN_W+1)'(1);
    illegal_o = (32'(need_o) > MAX_WORDS);
  end

endmodule

// File: rtl/instr_assembler.sv
// Variable-length instruction assembler.
// Collects WORD_W-bit words into a WORD_W*MAX_WORDS opcode (word0 in the
// MSBs), length taken from a field of word0, handshaked on both sides.
// Optional macro INSTR_ASM_LEN_ERR_EN: adds the err output and rejects
// word0 values whose length exceeds MAX_WORDS instead of clamping them.
module instr_assembler import instr_pkg::*; #(
  parameter int unsigned WORD_W    = INSTR_WORD_W,
  parameter int unsigned MAX_WORDS = INSTR_MAX_WORDS,
  parameter int unsigned LEN_LSB   = INSTR_LEN_LSB,
  parameter int unsigned LEN_W     = INSTR_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  instr_assembler_if.slave  bus
`ifdef INSTR_ASM_LEN_ERR_EN
  ,
  output logic              err
`endif
);

  localparam int unsigned OP_W = WORD_W * MAX_WORDS;
  localparam int unsigned LW   = $clog2(MAX_WORDS + 1);

  instr_state_e          state_q, state_d, start_state;
  logic [LW-1:0]         cnt_q, cnt_d;
  logic [OP_W-1:0]       opcode_q, opcode_d;
  logic [LW-1:0]         op_len_q, op_len_d;
  logic [LEN_W:0]        need_raw;
  logic [LW-1:0]         need_eff;
  logic                  len_illegal;
  logic                  reject;
  logic                  in_ready;
  logic                  op_valid;
  logic                  xfer_in, xfer_out;
  logic                  start, collect, last_word;
  logic [MAX_WORDS-1:0]  slot_sel;

  instr_len_decode #(
    .MAX_WORDS (MAX_WORDS),
    .LEN_W     (LEN_W)
  ) u_len_decode (
    .len_field_i (bus.in_word[LEN_LSB +: LEN_W]),
    .need_o      (need_raw),
    .illegal_o   (len_illegal)
  );

`ifdef INSTR_ASM_LEN_ERR_EN
  assign reject   = len_illegal;
  assign need_eff = LW'(need_raw);
`else
  assign reject   = 1'b0;
  assign need_eff = len_illegal ? LW'(MAX_WORDS) : LW'(need_raw);
`endif

  // Handshake outputs are a pure function of state; in DONE the input side
  // follows op_ready so a new word0 can land in the same cycle the result leaves
  always_comb begin
    op_valid = (state_q == DONE);
    in_ready = (state_q == DONE) ? bus.op_ready : 1'b1;
  end

  assign xfer_in  = bus.in_valid & in_ready;
  assign xfer_out = op_valid & bus.op_ready;
  // In DONE a transfer in implies a transfer out, so word0 capture is any
  // accepted word outside COLLECT
  assign start     = xfer_in & (state_q != COLLECT);
  assign collect   = xfer_in & (state_q == COLLECT);
  assign last_word = (LW'(cnt_q + LW'(1)) == op_len_q);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state selection; flush overrides everything
  always_comb begin
    if (reject)                     start_state = IDLE;
    else if (need_eff == LW'(1))    start_state = DONE;
    else                            start_state = COLLECT;

    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = start_state;
        COLLECT: if (collect && last_word) state_d = DONE;
        DONE: begin
          if (start)         state_d = start_state;
          else if (xfer_out) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // One-hot slot select from the word counter
  always_comb begin
    slot_sel = '0;
    for (int unsigned i = 0; i < MAX_WORDS; i++) begin
      slot_sel[i] = (cnt_q == LW'(i));
    end
  end

  // Datapath next values: word0 clears the opcode, later words fill their slot;
  // op_len doubles as the target length while collecting
  always_comb begin
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    op_len_d = op_len_q;
    if (flush) begin
      cnt_d = '0;
    end else if (start) begin
      cnt_d = '0;
      if (!reject) begin
        opcode_d                     = '0;
        opcode_d[OP_W-1 -: WORD_W]   = bus.in_word;
        op_len_d                     = need_eff;
        if (need_eff != LW'(1)) cnt_d = LW'(1);
      end
    end else if (collect) begin
      for (int unsigned i = 0; i < MAX_WORDS; i++) begin
        if (slot_sel[i]) opcode_d[OP_W-1-i*WORD_W -: WORD_W] = bus.in_word;
      end
      cnt_d = last_word ? '0 : LW'(cnt_q + LW'(1));
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      opcode_q <= '0;
      op_len_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      op_len_q <= op_len_d;
    end
  end

`ifdef INSTR_ASM_LEN_ERR_EN
  logic err_q;

  // Single-cycle pulse for a rejected word0
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= start & reject & ~flush;
  end

  assign err = err_q;
`endif

  assign bus.in_ready = in_ready;
  assign bus.op_valid = op_valid;
  assign bus.opcode   = opcode_q;
  assign bus.op_len   = op_len_q;

endmodule
